wb_stage: RTL

Writeback and branch-resolution stage of the SCC pipeline, sitting directly downstream of the execute stage. It accepts one executed instruction per cycle over a valid/ready handshake and commits the 33-bit result to an 8×32 register file. It also owns the CPSR flag register (N, C, Z, V) and the program counter. Conditional branches are resolved here against the committed CPSR, and a taken branch is signalled back to fetch with a one-cycle flush bubble.

---
 rtl/scc_pkg.sv | 38 +++
 rtl/wb_cond_eval.sv | 41 ++++
 rtl/wb_stage.sv | 129 ++++++++++++
 3 files changed

// File: rtl/scc_pkg.sv
// Shared definitions for the SCC pipeline: condition codes, class decode
// constants, writeback FSM states and CPSR flag bit positions.
package scc_pkg;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    // Class decode: first_ld value selecting move/shift, and alu_oc codes
    localparam logic [1:0] FIRST_LD_MOV     = 2'b00;
    localparam logic [2:0] MOV_LAST_WR_OC   = 3'b101;
    localparam logic [2:0] BR_UNCOND_OC     = 3'b000;
    localparam logic [2:0] BR_COND_OC       = 3'b001;

    localparam int FLAG_N = 3;
    localparam int FLAG_C = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_V = 0;

    typedef enum logic {
        WB_RUN,
        WB_FLUSH
    } wb_state_e;

endpackage

// File: rtl/wb_cond_eval.sv
// Branch condition evaluator: decides whether b_cond holds for a given
// set of committed flags. Purely combinational.
module wb_cond_eval
    import scc_pkg::*;
(
    input  logic [3:0] b_cond,
    input  logic [3:0] cpsr,
    output logic       take
);

    logic n, c, z, v;

    assign n = cpsr[FLAG_N];
    assign c = cpsr[FLAG_C];
    assign z = cpsr[FLAG_Z];
    assign v = cpsr[FLAG_V];

    always_comb begin
        take = 1'b0;
        case (b_cond)
            COND_EQ: take = z;
            COND_NE: take = !z;
            COND_CS: take = c;
            COND_CC: take = !c;
            COND_MI: take = n;
            COND_PL: take = !n;
            COND_VS: take = v;
            COND_VC: take = !v;
            COND_HI: take = c && !z;
            COND_LS: take = !(c && !z);
            COND_GE: take = (n == v);
            COND_LT: take = (n != v);
            COND_GT: take = !z && (n == v);
            COND_LE: take = !(!z && (n == v));
            COND_AL: take = 1'b1;
            COND_NV: take = 1'b0;
            default: take = 1'b0;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// Writeback and branch-resolution stage: commits results to the register
// file, maintains CPSR and PC, and resolves branches with a flush bubble.
module wb_stage
    import scc_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          NREGS    = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic [1:0]  first_ld,
    input  logic        special_encoding,
    input  logic [3:0]  second_ld,
    input  logic [2:0]  alu_oc,
    input  logic [3:0]  b_cond,
    input  logic [2:0]  dest_reg,
    input  logic [15:0] offset,
    input  logic [32:0] result,
    input  logic [3:0]  flags_in,
    input  logic [2:0]  rd_addr_a,
    input  logic [2:0]  rd_addr_b,
    output logic [31:0] rd_data_a,
    output logic [31:0] rd_data_b,
    output logic [3:0]  cpsr,
    output logic [31:0] pc,
    output logic        branch_taken,
    output logic [31:0] branch_target
);

    wb_state_e   state, state_next;
    logic [31:0] regs [NREGS];

    logic        accept;
    logic        is_alu, is_mov, is_branch;
    logic        rf_we;
    logic        cond_take;
    logic        br_take;
    logic [31:0] br_offset;
    logic [31:0] br_target_calc;
    logic        unused_inputs;

    assign ex_ready = (state == WB_RUN);
    assign accept   = ex_valid && ex_ready;

    assign is_alu    = special_encoding;
    assign is_mov    = !special_encoding && (first_ld == FIRST_LD_MOV);
    assign is_branch = !is_alu && !is_mov;

    assign rf_we = accept && (is_alu || (is_mov && (alu_oc <= MOV_LAST_WR_OC)));

    // Conditional branches see only flags committed by earlier instructions
    wb_cond_eval u_cond_eval (
        .b_cond (b_cond),
        .cpsr   (cpsr),
        .take   (cond_take)
    );

    assign br_take = accept && is_branch &&
                     ((alu_oc == BR_UNCOND_OC) || ((alu_oc == BR_COND_OC) && cond_take));

    assign br_offset      = {{14{offset[15]}}, offset, 2'b00};
    assign br_target_calc = pc + br_offset;

    // Carry-out travels in flags_in; low second_ld bits have no role here
    assign unused_inputs = ^{result[32], second_ld[2:0]};

    assign rd_data_a = (rf_we && (rd_addr_a == dest_reg)) ? result[31:0] : regs[rd_addr_a];
    assign rd_data_b = (rf_we && (rd_addr_b == dest_reg)) ? result[31:0] : regs[rd_addr_b];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (rf_we) begin
            regs[dest_reg] <= result[31:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cpsr <= '0;
        end else if (accept && is_alu) begin
            cpsr[FLAG_C] <= flags_in[FLAG_C];
            cpsr[FLAG_Z] <= flags_in[FLAG_Z];
            cpsr[FLAG_V] <= flags_in[FLAG_V];
            if (second_ld[3]) begin
                cpsr[FLAG_N] <= flags_in[FLAG_N];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc            <= RESET_PC;
            branch_taken  <= 1'b0;
            branch_target <= '0;
        end else begin
            branch_taken <= br_take;
            if (br_take) begin
                pc            <= br_target_calc;
                branch_target <= br_target_calc;
            end else if (accept) begin
                pc <= pc + 32'd4;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= WB_RUN;
        end else begin
            state <= state_next;
        end
    end

    // A taken branch costs exactly one bubble while fetch redirects
    always_comb begin
        state_next = state;
        case (state)
            WB_RUN:   if (br_take) state_next = WB_FLUSH;
            WB_FLUSH: state_next = WB_RUN;
            default:  state_next = WB_RUN;
        endcase
    end

endmodule
